// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU front end.
//   word_t         16-bit instruction/data word
//   addr_t         16-bit instruction address
//   fetch_state_t  fetch sequencer states (IDLE, RUN)
//   fetch_entry_t  instruction buffer payload {instr, pc}
//   RESET_PC_DEFAULT / FETCH_DEPTH  default fetch parameters
package cpu_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    addr_t pc;
  } fetch_entry_t;

  localparam addr_t RESET_PC_DEFAULT = 16'h0000;
  localparam int    FETCH_DEPTH      = 2;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry instruction buffer between memory and the consumer.
//   clk        clock, rising edge
//   rst        asynchronous active-low reset, empties the buffer
//   flush      synchronous empty; wins over push and pop
//   push       write push_data at the tail
//   push_data  {instr, pc} entry to store
//   pop        drop the head entry
//   head       current head entry (registered storage, never X)
//   count      number of valid entries, 0..2
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A full buffer may still accept a push when the head leaves in the same
  // cycle; the freed slot is exactly the one the write pointer points at.
  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = entry[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect and a 2-entry buffer.
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   enable       1 = fetching permitted
//   mem_wen      memory busy with a write this cycle; no read is issued
//   mem_raddr    read address (the PC register)
//   mem_rdata    read data, valid the cycle after an issued read
//   redirect     flush and restart fetching at redirect_pc
//   redirect_pc  new PC, sampled while redirect=1
//   instr        instruction at the buffer head
//   instr_pc     address of instr
//   instr_valid  buffer non-empty
//   instr_ready  consumer accepts the head this cycle
// Only DEPTH=2 is supported; the buffer is fixed at two entries.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        mem_wen,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam logic [2:0] DEPTH_LIM = 3'(DEPTH);

  fetch_state_t state_q;
  fetch_state_t state_d;
  addr_t        pc;
  addr_t        pc_q;
  logic         inflight;
  logic         issue;
  logic         push;
  logic         pop;
  logic [1:0]   fifo_count;
  logic [2:0]   credit_used;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign instr_valid = (fifo_count != 2'd0);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign push        = inflight & ~redirect;
  assign push_entry  = '{instr: mem_rdata, pc: pc_q};

  // Slots claimed by buffered entries plus the read in flight. The head
  // leaving this cycle returns its slot immediately, which is what lets the
  // unit sustain one instruction per cycle; the read issued now lands
  // next cycle, after that slot has been freed, so the buffer cannot overflow.
  assign credit_used = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue = (state_q == RUN) & ~mem_wen & ~redirect & (credit_used < DEPTH_LIM);
  end

  // Redirect wins over everything: the pending response is dropped by
  // clearing inflight, and issue is already suppressed combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc   <= pc + 16'd1;
        pc_q <= pc;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign mem_raddr = pc;
  assign instr     = head.instr;
  assign instr_pc  = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected {instr, pc} pairs
// are queued when a fetch stream is started (reset release or redirect) and
// compared against every accepted instruction. A second instance with
// RESET_PC=16'hFFFE exercises PC wrap-around.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_w;
  logic        enable;
  logic        mem_wen;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata = 16'h0000;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic [15:0] w_raddr;
  logic [15:0] w_rdata = 16'h0000;
  logic [15:0] w_instr;
  logic [15:0] w_instr_pc;
  logic        w_valid;

  exp_t sb[$];
  exp_t sbw[$];
  int   errors = 0;
  int   checks = 0;
  int   wcount = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mem_wen     (mem_wen),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut_w (
    .clk         (clk),
    .rst         (rst_w),
    .enable      (enable),
    .mem_wen     (mem_wen),
    .mem_raddr   (w_raddr),
    .mem_rdata   (w_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (w_instr),
    .instr_pc    (w_instr_pc),
    .instr_valid (w_valid),
    .instr_ready (instr_ready)
  );

  // Memory contents: a bijection of the address so every word is distinct.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hA5A0;
  endfunction

  // Synchronous-read memory models; a write cycle performs no read.
  always @(posedge clk) if (!mem_wen) mem_rdata <= memf(mem_raddr);
  always @(posedge clk) if (!mem_wen) w_rdata <= memf(w_raddr);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic wen);
    enable      = en;
    instr_ready = rdy;
    mem_wen     = wen;
  endtask

  task automatic pushExpected(input logic [15:0] start, input int n, input bit to_wrap);
    logic [15:0] a;
    exp_t e;
    a = start;
    for (int i = 0; i < n; i++) begin
      e.instr = memf(a);
      e.pc    = a;
      if (to_wrap) sbw.push_back(e);
      else         sb.push_back(e);
      a = a + 16'd1;
    end
  endtask

  task automatic checkStartup(input string tag);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid_early"}, 32'(instr_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(instr_pc), 32'h0000);
  endtask

  initial begin
    logic [15:0] stall_head;
    logic [15:0] r0;

    rst = 1'b0; rst_w = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0);

    fork
      forever begin
        @(negedge clk);
        if (rst && !redirect && instr_valid && instr_ready) begin
          checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_pc", 32'(instr_pc), 32'(e.pc));
            checkOutput("sb_instr", 32'(instr), 32'(e.instr));
          end
        end
        if (rst_w && !redirect && w_valid && instr_ready) begin
          checkOutput("sbw_nonempty", 32'(sbw.size() != 0), 32'd1);
          if (sbw.size() != 0) begin
            exp_t e;
            e = sbw.pop_front();
            checkOutput("sbw_pc", 32'(w_instr_pc), 32'(e.pc));
            checkOutput("sbw_instr", 32'(w_instr), 32'(e.instr));
            wcount++;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) tick();
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    checkOutput("rst_instr_pc", 32'(instr_pc), 32'd0);
    checkOutput("rst_raddr", 32'(mem_raddr), 32'h0000);
    checkOutput("rst_w_raddr", 32'(w_raddr), 32'hFFFE);
    checkOutput("rst_w_valid", 32'(w_valid), 32'd0);

    // Start-up: first instruction timing and full-rate streaming
    pushExpected(16'h0000, 300, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    checkStartup("start");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("steady_valid", 32'(instr_valid), 32'd1);
    end
    tick();

    // Consumer stall: buffer fills to two entries, PC stops
    applyStimulus(1'b1, 1'b0, 1'b0);
    stall_head = sb[0].pc;
    repeat (3) tick();
    checkOutput("stall_raddr_mid", 32'(mem_raddr), 32'(stall_head + 16'd2));
    repeat (2) tick();
    checkOutput("stall_raddr_end", 32'(mem_raddr), 32'(stall_head + 16'd2));
    checkOutput("stall_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_head_pc", 32'(instr_pc), 32'(stall_head));
    checkOutput("stall_head_instr", 32'(instr), 32'(memf(stall_head)));
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) tick();

    // Redirect with a full buffer
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("full_valid", 32'(instr_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    redirect = 1'b1; redirect_pc = 16'h0100;
    sb.delete();
    pushExpected(16'h0100, 300, 1'b0);
    tick();
    redirect = 1'b0;
    checkOutput("redir_raddr", 32'(mem_raddr), 32'h0100);
    @(negedge clk);
    checkOutput("redir_gap1", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("redir_first_issue", 32'(mem_raddr), 32'h0101);
    @(negedge clk);
    checkOutput("redir_gap2", 32'(instr_valid), 32'd0);
    @(negedge clk);
    checkOutput("redir_valid", 32'(instr_valid), 32'd1);
    checkOutput("redir_pc", 32'(instr_pc), 32'h0100);
    tick();

    // Redirect mid-stream with a read in flight
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 16'h0200;
    sb.delete();
    pushExpected(16'h0200, 300, 1'b0);
    tick();
    redirect = 1'b0;
    checkOutput("redir2_raddr", 32'(mem_raddr), 32'h0200);
    repeat (6) tick();

    // Memory write cycles block issue for three cycles
    r0 = sb[0].pc + 16'd2;
    checkOutput("steady_raddr", 32'(mem_raddr), 32'(r0));
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("wen_hold", 32'(mem_raddr), 32'(r0));
    checkOutput("wen_drained", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("wen_resume", 32'(mem_raddr), 32'(r0 + 16'd1));
    repeat (5) tick();

    // Disable: last issue still completes and is delivered
    r0 = sb[0].pc + 16'd2;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("disable_last_issue", 32'(mem_raddr), 32'(r0 + 16'd1));
    repeat (3) tick();
    checkOutput("disable_hold", 32'(mem_raddr), 32'(r0 + 16'd1));
    checkOutput("disable_drained", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (6) tick();

    // Asynchronous reset mid-stream
    checkOutput("pre_reset_valid", 32'(instr_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_valid", 32'(instr_valid), 32'd0);
    checkOutput("async_instr", 32'(instr), 32'd0);
    checkOutput("async_instr_pc", 32'(instr_pc), 32'd0);
    checkOutput("async_raddr", 32'(mem_raddr), 32'h0000);
    sb.delete();
    repeat (2) tick();
    pushExpected(16'h0000, 300, 1'b0);
    rst = 1'b1;
    checkStartup("restart");
    tick();
    repeat (6) tick();

    // PC wrap-around on the RESET_PC=FFFE instance
    pushExpected(16'hFFFE, 100, 1'b1);
    rst_w = 1'b1;
    repeat (12) tick();
    checkOutput("wrap_delivered", 32'(wcount >= 4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
